// File: rtl/datapath_mac_pkg.sv
// datapath_mac_pkg: select encodings and Q-format defaults shared with the sequencer
package datapath_mac_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC = 8;
  typedef enum logic [1:0] {FUN_ZERO = 2'b00, FUN_FK = 2'b01, FUN_X = 2'b10, FUN_YPREV = 2'b11} fun_e;
  typedef enum logic [1:0] {ACC_CLR = 2'b00, ACC_ADD = 2'b01, ACC_XFER = 2'b10, ACC_HOLD = 2'b11} acum_e;
endpackage

// File: rtl/datapath_mac_if.sv
// datapath_mac_if: sequencer-to-datapath select lines and filter outputs
interface datapath_mac_if #(parameter int WIDTH = 16);
  logic start;
  logic signed [WIDTH-1:0] x_in;
  logic [2:0] sel_const;
  logic [1:0] sel_fun;
  logic [1:0] sel_acum;
  logic band_listo;
  logic senal;
  logic signed [WIDTH-1:0] y_out;
  logic y_valid;
  logic sample_req;
  logic ovf;
  modport master(output start, x_in, sel_const, sel_fun, sel_acum, band_listo, senal,
                 input y_out, y_valid, sample_req, ovf);
  modport slave(input start, x_in, sel_const, sel_fun, sel_acum, band_listo, senal,
                output y_out, y_valid, sample_req, ovf);
endinterface

// File: rtl/datapath_mac_sat_mul.sv
// sat_mul: signed multiply, arithmetic shift by FRAC, saturate back to WIDTH
module sat_mul #(
  parameter int WIDTH = 16,
  parameter int FRAC = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    ovf
);
  localparam logic signed [2*WIDTH-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] sh;
  always_comb begin
    full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    sh = full >>> FRAC;
    ovf = (sh > MAXV) || (sh < MINV);
    p = sh > MAXV ? MAXV[WIDTH-1:0] : sh < MINV ? MINV[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/datapath_mac.sv
// datapath_mac: fixed-point MAC datapath producing y = sum(c_i * f_i) per sequence
module datapath_mac
  import datapath_mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC = DEF_FRAC,
  parameter logic signed [WIDTH-1:0] C0 = WIDTH'(16'h0100),
  parameter logic signed [WIDTH-1:0] C1 = WIDTH'(16'h0080),
  parameter logic signed [WIDTH-1:0] C2 = WIDTH'(16'h0040),
  parameter logic signed [WIDTH-1:0] C3 = WIDTH'(16'h0200),
  parameter logic signed [WIDTH-1:0] C4 = WIDTH'(16'h0080)
) (
  input logic           clk,
  input logic           rst_n,
  datapath_mac_if.slave bus
);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic signed [WIDTH-1:0] x_q, x_d, acc_q, acc_d, fk_q, fk_d, y_prev_q, y_prev_d, y_out_q, y_out_d;
  logic listo_q, listo_d, y_valid_q, y_valid_d, sample_req_q, sample_req_d, ovf_q, ovf_d;
  logic signed [WIDTH-1:0] c, f, prod, sum;
  logic signed [WIDTH:0] wide;
  logic prod_ovf, sum_ovf, capture, use_prod, use_sum;
  sat_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (.a(c), .b(f), .p(prod), .ovf(prod_ovf));
  always_comb begin
    c = bus.sel_const == 3'd0 ? C0 : bus.sel_const == 3'd1 ? C1 : bus.sel_const == 3'd2 ? C2 :
        bus.sel_const == 3'd3 ? C3 : bus.sel_const == 3'd4 ? C4 : '0;
    f = bus.sel_fun == FUN_FK ? fk_q : bus.sel_fun == FUN_X ? x_q : bus.sel_fun == FUN_YPREV ? y_prev_q : '0;
    wide = (WIDTH+1)'(acc_q) + (WIDTH+1)'(prod);
    sum_ovf = wide[WIDTH] != wide[WIDTH-1];
    sum = sum_ovf ? (wide[WIDTH] ? SMIN : SMAX) : wide[WIDTH-1:0];
    capture = bus.band_listo && !listo_q;
    use_sum = bus.sel_acum == ACC_ADD || capture;
    use_prod = use_sum || bus.sel_acum == ACC_XFER;
    acc_d = bus.start || bus.sel_acum == ACC_CLR ? '0 : bus.sel_acum == ACC_ADD ? sum :
            bus.sel_acum == ACC_XFER ? prod : acc_q;
    fk_d = !bus.start && bus.sel_acum == ACC_XFER ? acc_q : fk_q;
    x_d = bus.start ? bus.x_in : x_q;
    y_out_d = capture ? sum : y_out_q;
    y_prev_d = capture ? sum : y_prev_q;
    y_valid_d = capture;
    listo_d = bus.band_listo;
    sample_req_d = bus.senal;
    ovf_d = bus.start ? 1'b0 : ovf_q | (prod_ovf & use_prod) | (sum_ovf & use_sum);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      acc_q <= '0;
      fk_q <= '0;
      y_prev_q <= '0;
      y_out_q <= '0;
      listo_q <= 1'b0;
      y_valid_q <= 1'b0;
      sample_req_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      x_q <= x_d;
      acc_q <= acc_d;
      fk_q <= fk_d;
      y_prev_q <= y_prev_d;
      y_out_q <= y_out_d;
      listo_q <= listo_d;
      y_valid_q <= y_valid_d;
      sample_req_q <= sample_req_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.y_out = y_out_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sample_req = sample_req_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_datapath_mac.sv
// tb_datapath_mac: directed vector table plus hand sequences for the MAC datapath
module tb_datapath_mac;
  typedef struct {
    logic        st;
    logic [15:0] x;
    logic [2:0]  c;
    logic [1:0]  f;
    logic [1:0]  a;
    logic        l;
    logic        s;
    logic [15:0] ey;
    logic        ev;
    logic        er;
    logic        eo;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t tbl [29];
  datapath_mac_if bus();
  datapath_mac dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic st, logic [15:0] x, logic [2:0] c, logic [1:0] f, logic [1:0] a,
                              logic l, logic s, logic [15:0] ey, logic ev, logic er, logic eo);
    vec_t v;
    v.st = st; v.x = x; v.c = c; v.f = f; v.a = a; v.l = l; v.s = s;
    v.ey = ey; v.ev = ev; v.er = er; v.eo = eo;
    return v;
  endfunction
  task automatic drive(logic st, logic [15:0] x, logic [2:0] c, logic [1:0] f, logic [1:0] a, logic l, logic s);
    bus.start = st;
    bus.x_in = x;
    bus.sel_const = c;
    bus.sel_fun = f;
    bus.sel_acum = a;
    bus.band_listo = l;
    bus.senal = s;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  initial begin
    tbl[0]  = mk(1, 16'h0200, 0, 0, 3, 0, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(0, 16'h0000, 0, 2, 1, 0, 1, 16'h0000, 0, 1, 0);
    tbl[3]  = mk(0, 16'h0000, 1, 3, 1, 0, 0, 16'h0000, 0, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 2, 1, 2, 0, 0, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(0, 16'h0000, 3, 2, 1, 0, 0, 16'h0000, 0, 0, 0);
    tbl[6]  = mk(0, 16'h0000, 4, 3, 1, 1, 0, 16'h0400, 1, 0, 0);
    tbl[7]  = mk(1, 16'h0200, 0, 0, 0, 0, 0, 16'h0400, 0, 0, 0);
    tbl[8]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0400, 0, 0, 0);
    tbl[9]  = mk(0, 16'h0000, 0, 2, 1, 0, 0, 16'h0400, 0, 0, 0);
    tbl[10] = mk(0, 16'h0000, 1, 3, 1, 0, 0, 16'h0400, 0, 0, 0);
    tbl[11] = mk(0, 16'h0000, 2, 1, 2, 0, 0, 16'h0400, 0, 0, 0);
    tbl[12] = mk(0, 16'h0000, 3, 2, 1, 0, 0, 16'h0400, 0, 0, 0);
    tbl[13] = mk(0, 16'h0000, 4, 3, 1, 1, 0, 16'h0680, 1, 0, 0);
    tbl[14] = mk(1, 16'h0200, 0, 0, 3, 0, 0, 16'h0680, 0, 0, 0);
    tbl[15] = mk(0, 16'h0000, 0, 2, 1, 0, 0, 16'h0680, 0, 0, 0);
    tbl[16] = mk(0, 16'h0000, 5, 0, 3, 1, 0, 16'h0200, 1, 0, 0);
    tbl[17] = mk(1, 16'h7F00, 0, 0, 3, 0, 0, 16'h0200, 0, 0, 0);
    tbl[18] = mk(0, 16'h0000, 3, 2, 1, 0, 0, 16'h0200, 0, 0, 1);
    tbl[19] = mk(0, 16'h0000, 5, 0, 3, 1, 0, 16'h7FFF, 1, 0, 1);
    tbl[20] = mk(1, 16'h8100, 0, 0, 3, 0, 0, 16'h7FFF, 0, 0, 0);
    tbl[21] = mk(0, 16'h0000, 3, 2, 1, 0, 0, 16'h7FFF, 0, 0, 1);
    tbl[22] = mk(0, 16'h0000, 7, 2, 1, 0, 1, 16'h7FFF, 0, 1, 1);
    tbl[23] = mk(0, 16'h0000, 0, 0, 3, 1, 0, 16'h8000, 1, 0, 1);
    tbl[24] = mk(1, 16'h0000, 0, 0, 3, 0, 0, 16'h8000, 0, 0, 0);
    tbl[25] = mk(1, 16'hFFFF, 0, 0, 3, 0, 0, 16'h8000, 0, 0, 0);
    tbl[26] = mk(0, 16'h0000, 1, 2, 1, 0, 0, 16'h8000, 0, 0, 0);
    tbl[27] = mk(0, 16'h0000, 5, 0, 3, 1, 0, 16'hFFFF, 1, 0, 0);
    tbl[28] = mk(0, 16'h0000, 0, 0, 3, 0, 0, 16'hFFFF, 0, 0, 0);
    drive(0, 0, 0, 0, 3, 0, 0);
    tick();
    tick();
    chk("reset y_out", bus.y_out, 16'h0000);
    chk("reset y_valid", 16'(bus.y_valid), 16'h0);
    chk("reset sample_req", 16'(bus.sample_req), 16'h0);
    chk("reset ovf", 16'(bus.ovf), 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].st, tbl[i].x, tbl[i].c, tbl[i].f, tbl[i].a, tbl[i].l, tbl[i].s);
      tick();
      chk($sformatf("vec%0d y_out", i), bus.y_out, tbl[i].ey);
      chk($sformatf("vec%0d y_valid", i), 16'(bus.y_valid), 16'(tbl[i].ev));
      chk($sformatf("vec%0d sample_req", i), 16'(bus.sample_req), 16'(tbl[i].er));
      chk($sformatf("vec%0d ovf", i), 16'(bus.ovf), 16'(tbl[i].eo));
    end
    drive(1, 16'h7F00, 0, 0, 3, 0, 0);
    tick();
    drive(0, 0, 3, 2, 1, 0, 0);
    tick();
    chk("pre-reset ovf", 16'(bus.ovf), 16'h1);
    rst_n = 1'b0;
    drive(0, 0, 3, 2, 1, 1, 1);
    tick();
    chk("midrst y_out", bus.y_out, 16'h0000);
    chk("midrst y_valid", 16'(bus.y_valid), 16'h0);
    chk("midrst sample_req", 16'(bus.sample_req), 16'h0);
    chk("midrst ovf", 16'(bus.ovf), 16'h0);
    rst_n = 1'b1;
    drive(0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(0, 0, 5, 0, 3, 1, 0);
    tick();
    chk("midrst acc/y_prev probe", bus.y_out, 16'h0000);
    chk("midrst probe valid", 16'(bus.y_valid), 16'h1);
    drive(0, 0, 0, 0, 3, 0, 0);
    tick();
    drive(1, 16'h0100, 0, 0, 3, 0, 0);
    tick();
    drive(0, 0, 0, 2, 1, 0, 0);
    tick();
    drive(0, 0, 0, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("held listo valid %0d", i), 16'(bus.y_valid), 16'(i == 0));
      chk($sformatf("held listo y_out %0d", i), bus.y_out, 16'h0200);
    end
    drive(0, 0, 0, 0, 3, 0, 0);
    tick();
    chk("held listo release valid", 16'(bus.y_valid), 16'h0);
    drive(1, 16'h0000, 5, 0, 3, 1, 0);
    tick();
    chk("start+capture y_out", bus.y_out, 16'h0400);
    chk("start+capture valid", 16'(bus.y_valid), 16'h1);
    drive(0, 0, 0, 0, 3, 0, 0);
    tick();
    drive(0, 0, 5, 0, 3, 1, 0);
    tick();
    chk("start cleared acc", bus.y_out, 16'h0000);
    drive(1, 16'h7F00, 0, 0, 3, 0, 0);
    tick();
    drive(0, 0, 0, 2, 1, 0, 0);
    tick();
    chk("no sum clamp yet", 16'(bus.ovf), 16'h0);
    tick();
    chk("sum clamp ovf", 16'(bus.ovf), 16'h1);
    drive(0, 0, 5, 0, 3, 1, 0);
    tick();
    chk("sum clamp value", bus.y_out, 16'h7FFF);
    drive(0, 0, 0, 0, 3, 0, 0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
